// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-port memory arbiter between CPU and debug/loader with halt support.
// Define MEM_BUS_ARB_STEAL_EN to enable the starvation counter and one-cycle STEAL state.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cpuCycle,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [11:0] cpuAddr,
    input  logic [3:0]  cpuWdata,
    output logic        cpuGnt,
    output logic        cpuStall,
    input  logic        dbgReq,
    input  logic        dbgWe,
    input  logic [11:0] dbgAddr,
    input  logic [3:0]  dbgWdata,
    output logic        dbgGnt,
    input  logic        dbgHaltReq,
    output logic        dbgHalted,
    output logic        memRe,
    output logic        memWe,
    output logic [11:0] memAddr,
    output logic [3:0]  memWdata,
    input  logic [3:0]  memRdata,
    output logic [3:0]  rdata,
    output logic        cpuRvalid,
    output logic        dbgRvalid
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end
`ifdef MEM_BUS_ARB_STEAL_EN
    typedef enum logic [1:0] {RUN, STEAL, HALT_PEND, HALTED} state_t;
`else
    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
`endif
    state_t state_q, state_d, run_nxt;
    logic [3:0] rdata_q, rdata_d;
    logic cpu_rv_q, cpu_rv_d, dbg_rv_q, dbg_rv_d;
    logic cpu_own, dbg_slot;
`ifdef MEM_BUS_ARB_STEAL_EN
    logic [3:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = (state_q == RUN && dbgReq && !dbgGnt) ? cnt_q + 4'd1 : 4'd0;
        run_nxt = (cnt_d == 4'(STARVE_LIMIT)) ? STEAL : RUN;
        dbg_slot = state_q == HALTED || state_q == STEAL;
    end
`else
    always_comb begin
        run_nxt = RUN;
        dbg_slot = state_q == HALTED;
    end
`endif
    // Grants are gated by rst so the bus is quiet for the whole reset pulse.
    always_comb begin
        cpu_own = state_q == RUN || state_q == HALT_PEND;
        cpuGnt = !rst && cpu_own && cpuReq;
        dbgGnt = !rst && dbgReq && (dbg_slot || (cpu_own && !cpuReq));
        memRe = (cpuGnt && !cpuWe) || (dbgGnt && !dbgWe);
        memWe = (cpuGnt && cpuWe) || (dbgGnt && dbgWe);
        memAddr = cpuGnt ? cpuAddr : dbgGnt ? dbgAddr : 12'd0;
        memWdata = cpuGnt ? cpuWdata : dbgGnt ? dbgWdata : 4'd0;
        cpuStall = state_q != RUN && state_q != HALT_PEND;
        dbgHalted = state_q == HALTED;
        rdata = rdata_q;
        cpuRvalid = cpu_rv_q;
        dbgRvalid = dbg_rv_q;
        rdata_d = memRe ? memRdata : rdata_q;
        cpu_rv_d = cpuGnt && !cpuWe;
        dbg_rv_d = dbgGnt && !dbgWe;
        state_d = state_q == RUN ? (dbgHaltReq ? HALT_PEND : run_nxt) :
                  state_q == HALT_PEND ? (!dbgHaltReq ? RUN : cpuCycle == 3'd7 ? HALTED : HALT_PEND) :
                  state_q == HALTED ? (dbgHaltReq ? HALTED : RUN) : RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            rdata_q <= 4'd0;
            cpu_rv_q <= 1'b0;
            dbg_rv_q <= 1'b0;
`ifdef MEM_BUS_ARB_STEAL_EN
            cnt_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            cpu_rv_q <= cpu_rv_d;
            dbg_rv_q <= dbg_rv_d;
`ifdef MEM_BUS_ARB_STEAL_EN
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (default STARVE_LIMIT=8).
module tb_mem_bus_arbiter;
`ifdef MEM_BUS_ARB_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic [2:0] cpuCycle = '0;
    logic cpuReq = 0, cpuWe = 0, dbgReq = 0, dbgWe = 0, dbgHaltReq = 0;
    logic [11:0] cpuAddr = '0, dbgAddr = '0;
    logic [3:0] cpuWdata = '0, dbgWdata = '0, memRdata = '0;
    logic cpuGnt, cpuStall, dbgGnt, dbgHalted, memRe, memWe, cpuRvalid, dbgRvalid;
    logic [11:0] memAddr;
    logic [3:0] memWdata, rdata;
    typedef struct packed {logic c; logic d; logic [3:0] v;} rd_t;
    rd_t sb[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst), .cpuCycle(cpuCycle), .cpuReq(cpuReq), .cpuWe(cpuWe),
        .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuGnt(cpuGnt), .cpuStall(cpuStall),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgGnt(dbgGnt), .dbgHaltReq(dbgHaltReq), .dbgHalted(dbgHalted),
        .memRe(memRe), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .rdata(rdata), .cpuRvalid(cpuRvalid), .dbgRvalid(dbgRvalid)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".gnt"}, {cpuGnt, dbgGnt}, 0);
        chk({tag, ".strobe"}, {memRe, memWe}, 0);
        chk({tag, ".addr"}, memAddr, 0);
        chk({tag, ".wdata"}, memWdata, 0);
        chk({tag, ".stall_halt"}, {cpuStall, dbgHalted}, 0);
        chk({tag, ".rvalid"}, {cpuRvalid, dbgRvalid}, 0);
        chk({tag, ".rdata"}, rdata, 0);
    endtask

    // Inputs are already set; checks this cycle's grants/strobes, then the read return next cycle.
    task automatic cyc(input string tag, input logic ecg, input logic edg, input logic est, input logic ehl);
        logic ere, ewe;
        rd_t r;
        ere = (ecg & ~cpuWe) | (edg & ~dbgWe);
        ewe = (ecg & cpuWe) | (edg & dbgWe);
        #1;
        chk({tag, ".cpuGnt"}, cpuGnt, ecg);
        chk({tag, ".dbgGnt"}, dbgGnt, edg);
        chk({tag, ".memRe"}, memRe, ere);
        chk({tag, ".memWe"}, memWe, ewe);
        chk({tag, ".cpuStall"}, cpuStall, est);
        chk({tag, ".dbgHalted"}, dbgHalted, ehl);
        if (ere | ewe) chk({tag, ".memAddr"}, memAddr, ecg ? cpuAddr : dbgAddr);
        if (ewe) chk({tag, ".memWdata"}, memWdata, ecg ? cpuWdata : dbgWdata);
        sb.push_back(rd_t'{ecg & ~cpuWe, edg & ~dbgWe, memRdata});
        @(posedge clk);
        #1;
        r = sb.pop_front();
        chk({tag, ".cpuRvalid"}, cpuRvalid, r.c);
        chk({tag, ".dbgRvalid"}, dbgRvalid, r.d);
        if (r.c | r.d) chk({tag, ".rdata"}, rdata, r.v);
    endtask

    initial begin
        #1 rst = 1'b1;
        cpuReq = 1; dbgReq = 1; cpuAddr = 12'h123;
        #2 rst_chk("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        cpuReq = 0; dbgReq = 0;
        cpuWe = 0; cpuAddr = 12'h123; memRdata = 4'h5;
        cpuReq = 1; cyc("cpu_rd", 1, 0, 0, 0);
        cpuReq = 0; dbgReq = 1; dbgWe = 1; dbgAddr = 12'hFF3; dbgWdata = 4'hA;
        cyc("dbg_wr", 0, 1, 0, 0);
        cpuReq = 1; cpuAddr = 12'h0AB; memRdata = 4'h3; dbgReq = 0;
        cyc("b2b_cpu", 1, 0, 0, 0);
        cpuReq = 0; dbgReq = 1; dbgWe = 0; dbgAddr = 12'h456; memRdata = 4'h9;
        cyc("b2b_dbg", 0, 1, 0, 0);
        cpuReq = 1; cpuWe = 1; cpuAddr = 12'h777; cpuWdata = 4'h6; dbgReq = 0;
        cyc("cpu_wr", 1, 0, 0, 0);
        cpuWe = 0; cpuAddr = 12'h200; dbgReq = 1; dbgWe = 0; dbgAddr = 12'h300;
        for (int i = 1; i <= 9; i++) begin
            memRdata = i[3:0];
            if (i < 9) cyc("starve", 1, 0, 0, 0);
            else cyc("steal", !STEAL, STEAL, STEAL, 0);
        end
        dbgReq = 0; cyc("post_steal", 1, 0, 0, 0);
        dbgHaltReq = 1;
        for (int c = 2; c <= 7; c++) begin
            cpuCycle = c[2:0];
            cyc("halt_pend", 1, 0, 0, 0);
        end
        cpuCycle = 0; dbgReq = 1; dbgWe = 1; dbgAddr = 12'h010; dbgWdata = 4'h3;
        cyc("halted_wr", 0, 1, 1, 1);
        dbgWe = 0; memRdata = 4'hC; cyc("halted_rd", 0, 1, 1, 1);
        dbgReq = 0; dbgHaltReq = 0; cyc("halted_rel", 0, 0, 1, 1);
        cyc("run_again", 1, 0, 0, 0);
        dbgHaltReq = 1; cpuCycle = 5; cyc("pend_enter", 1, 0, 0, 0);
        cpuReq = 0; dbgReq = 1; memRdata = 4'h7; cpuCycle = 6; cyc("pend_dbg", 0, 1, 0, 0);
        dbgHaltReq = 0; cpuReq = 1; dbgReq = 0; cpuCycle = 7; cyc("pend_cancel", 1, 0, 0, 0);
        cpuCycle = 0; cyc("cancel_run", 1, 0, 0, 0);
        cpuAddr = 12'h5A5; memRdata = 4'hF;
        #1 chk("mid_rd.cpuGnt", cpuGnt, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        dbgReq = 1;
        #1 rst_chk("rst_mid");
        @(negedge clk);
        rst = 1'b0; cpuReq = 0; dbgReq = 0;
        @(posedge clk);
        #1 chk("post_rst.rvalid", {cpuRvalid, dbgRvalid}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
